dekatron_counter_arbiter: RTL and testbench

// Shares one DekatronCounter (pointer or loop counter) between N requesters, for example the

---
 rtl/dcnt_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 26 ++
 rtl/dekatron_counter_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dekatron_counter_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcnt_arb_pkg.sv
// Shared types for the dekatron counter arbiter.
// DEKATRON_WIDTH is the BCD width of one dekatron digit, kept in step with parameters.sv.
package dcnt_arb_pkg;

    localparam int unsigned DEKATRON_WIDTH = 4;
    localparam int unsigned OP_W           = 2;

    typedef enum logic [1:0] {
        OpInc  = 2'b00,
        OpDec  = 2'b01,
        OpSet  = 2'b10,
        OpRead = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StWait  = 2'b10,
        StDone  = 2'b11
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: grants the first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o
);

    always_comb begin
        logic        found;
        int unsigned idx;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dekatron_counter_arbiter.sv
// Shares one dekatron counter between N_REQ requesters with round-robin grants.
// Optional DCNT_ARB_BURST_EN: INC/DEC repeat Burst times under a single grant.
module dekatron_counter_arbiter
    import dcnt_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned D_NUM   = 3,
    parameter int unsigned WIDTH   = D_NUM * DEKATRON_WIDTH,
    parameter int unsigned BURST_W = 4
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [N_REQ-1:0]         Req,
    input  logic [OP_W*N_REQ-1:0]    Op,
    input  logic [WIDTH*N_REQ-1:0]   Data,
    input  logic [BURST_W*N_REQ-1:0] Burst,
    output logic [N_REQ-1:0]         Grant,
    output logic [N_REQ-1:0]         Ack,
    output logic [WIDTH-1:0]         Result,
    output logic                     ResultZero,
    output logic                     CntRequest,
    output logic                     CntDec,
    output logic                     CntSet,
    output logic [WIDTH-1:0]         CntIn,
    input  logic                     CntReady,
    input  logic                     CntZero,
    input  logic [WIDTH-1:0]         CntOut
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]   cnt_in_q, cnt_in_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               result_zero_q, result_zero_d;
    logic               guard_q, guard_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [PTR_W-1:0]   sel_idx;
    logic [OP_W-1:0]    sel_op;
    logic [WIDTH-1:0]   sel_data;

`ifdef DCNT_ARB_BURST_EN
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] sel_burst;
`else
    logic               unused_burst;
    assign unused_burst = ^Burst;
`endif

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req_i (Req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    // Pick the winner's fields out of the packed per-requester buses.
    always_comb begin
        sel_idx   = '0;
        sel_op    = Op[OP_W-1:0];
        sel_data  = Data[WIDTH-1:0];
`ifdef DCNT_ARB_BURST_EN
        sel_burst = Burst[BURST_W-1:0];
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_idx   = PTR_W'(i);
                sel_op    = Op[i*OP_W +: OP_W];
                sel_data  = Data[i*WIDTH +: WIDTH];
`ifdef DCNT_ARB_BURST_EN
                sel_burst = Burst[i*BURST_W +: BURST_W];
`endif
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        cnt_in_d      = cnt_in_q;
        result_d      = result_q;
        result_zero_d = result_zero_q;
        guard_d       = guard_q;
`ifdef DCNT_ARB_BURST_EN
        burst_d       = burst_q;
`endif
        unique case (state_q)
            StIdle: begin
                if ((|Req) && CntReady) begin
                    owner_d  = sel_idx;
                    op_d     = op_t'(sel_op);
                    cnt_in_d = sel_data;
`ifdef DCNT_ARB_BURST_EN
                    burst_d  = (sel_burst == '0) ? BURST_W'(1) : sel_burst;
`endif
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                guard_d = 1'b1;
                state_d = (op_q == OpRead) ? StDone : StWait;
            end
            StWait: begin
                // Counter may still show the stale Ready in the first cycle after Request.
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (CntReady) begin
`ifdef DCNT_ARB_BURST_EN
                    if ((op_q == OpInc || op_q == OpDec) && burst_q > BURST_W'(1)) begin
                        burst_d = burst_q - 1'b1;
                        state_d = StIssue;
                    end else begin
                        state_d = StDone;
                    end
`else
                    state_d = StDone;
`endif
                end
            end
            StDone: begin
                result_d      = CntOut;
                result_zero_d = CntZero;
                ptr_d         = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= StIdle;
            op_q          <= OpInc;
            owner_q       <= '0;
            ptr_q         <= '0;
            cnt_in_q      <= '0;
            result_q      <= '0;
            result_zero_q <= 1'b1;
            guard_q       <= 1'b0;
`ifdef DCNT_ARB_BURST_EN
            burst_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            cnt_in_q      <= cnt_in_d;
            result_q      <= result_d;
            result_zero_q <= result_zero_d;
            guard_q       <= guard_d;
`ifdef DCNT_ARB_BURST_EN
            burst_q       <= burst_d;
`endif
        end
    end

    always_comb begin
        Grant = '0;
        Ack   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            Grant[i] = (state_q != StIdle) && (owner_q == PTR_W'(i));
            Ack[i]   = (state_q == StDone) && (owner_q == PTR_W'(i));
        end
    end

    assign CntRequest = (state_q == StIssue) && (op_q != OpRead);
    assign CntDec     = (state_q != StIdle) && (op_q == OpDec);
    assign CntSet     = (state_q != StIdle) && (op_q == OpSet);
    assign CntIn      = cnt_in_q;
    assign Result     = result_q;
    assign ResultZero = result_zero_q;

endmodule

// File: tb/tb_dekatron_counter_arbiter.sv
// Randomised bench for dekatron_counter_arbiter with a behavioural counter and a
// transaction-level round-robin scoreboard.
module tb_dekatron_counter_arbiter;

    localparam int N  = 3;
    localparam int W  = 12;
    localparam int BW = 4;

    logic          Clk;
    logic          Rst_n;
    logic [N-1:0]  Req;
    logic [2*N-1:0] Op;
    logic [W*N-1:0] Data;
    logic [BW*N-1:0] Burst;
    logic [N-1:0]  Grant;
    logic [N-1:0]  Ack;
    logic [W-1:0]  Result;
    logic          ResultZero;
    logic          CntRequest;
    logic          CntDec;
    logic          CntSet;
    logic [W-1:0]  CntIn;
    logic          CntReady;
    logic          CntZero;
    logic [W-1:0]  CntOut;

    int n_checks = 0;
    int n_fail   = 0;

    dekatron_counter_arbiter #(
        .N_REQ   (N),
        .D_NUM   (3),
        .WIDTH   (W),
        .BURST_W (BW)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Req        (Req),
        .Op         (Op),
        .Data       (Data),
        .Burst      (Burst),
        .Grant      (Grant),
        .Ack        (Ack),
        .Result     (Result),
        .ResultZero (ResultZero),
        .CntRequest (CntRequest),
        .CntDec     (CntDec),
        .CntSet     (CntSet),
        .CntIn      (CntIn),
        .CntReady   (CntReady),
        .CntZero    (CntZero),
        .CntOut     (CntOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [11:0] int2bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Behavioural counter: one step per Request, busy for 1..3 cycles afterwards.
    int   cnt_val = 0;
    int   busy    = 0;
    logic force_nr = 1'b0;
    assign CntReady = (busy == 0) && !force_nr;
    assign CntOut   = int2bcd(cnt_val);
    assign CntZero  = (cnt_val == 0);

    always @(posedge Clk) begin
        if (busy > 0) busy <= busy - 1;
        if (CntRequest) begin
            busy <= $urandom_range(1, 3);
            if (CntSet)      cnt_val <= bcd2int(CntIn);
            else if (CntDec) cnt_val <= (cnt_val + 999) % 1000;
            else             cnt_val <= (cnt_val + 1) % 1000;
        end
    end

    // Scoreboard state.
    int           model_ptr = 0;
    bit           busy_m = 0;
    bit           chk_result = 0;
    int           exp_owner = 0;
    int           exp_result = 0;
    int           ref_val = 0;
    int           m_steps = 0;
    int           m_steps_exp = 0;
    logic [1:0]   m_op = 2'b00;
    logic [11:0]  m_data = '0;
    logic [N-1:0] acked = '0;

    always begin
        @(posedge Clk);
        #2;
        acked = '0;
        if (!Rst_n) begin
            busy_m     = 0;
            model_ptr  = 0;
            chk_result = 0;
        end else begin
            if (chk_result) begin
                check("result", 32'(Result), 32'(int2bcd(exp_result)));
                check("result_zero", 32'(ResultZero), 32'(exp_result == 0));
                chk_result = 0;
            end
            if (busy_m) check("grant_hold", 32'(Grant), 32'(onehot(exp_owner)));
            if (!busy_m && Grant != '0) begin
                int sel;
                int b;
                exp_owner = rr_pick(Req, model_ptr);
                check("grant", 32'(Grant), 32'(onehot(exp_owner)));
                sel    = (exp_owner < 0) ? 0 : exp_owner;
                m_op   = Op[2*sel +: 2];
                m_data = Data[W*sel +: W];
                b      = int'(Burst[BW*sel +: BW]);
                if (m_op == 2'b11)      m_steps_exp = 0;
                else if (m_op == 2'b10) m_steps_exp = 1;
`ifdef DCNT_ARB_BURST_EN
                else                    m_steps_exp = (b == 0) ? 1 : b;
`else
                else                    m_steps_exp = 1;
`endif
                m_steps = 0;
                busy_m  = 1;
            end
            if (CntRequest) begin
                m_steps++;
                check("cnt_set", 32'(CntSet), 32'(m_op == 2'b10));
                check("cnt_dec", 32'(CntDec), 32'(m_op == 2'b01));
                check("cnt_in", 32'(CntIn), 32'(m_data));
                case (m_op)
                    2'b00:   ref_val = (ref_val + 1) % 1000;
                    2'b01:   ref_val = (ref_val + 999) % 1000;
                    2'b10:   ref_val = bcd2int(m_data);
                    default: ref_val = ref_val;
                endcase
            end
            if (Ack != '0) begin
                check("ack", 32'(Ack), 32'(onehot(exp_owner)));
                check("steps", 32'(m_steps), 32'(m_steps_exp));
                acked      = Ack;
                model_ptr  = (exp_owner + 1) % N;
                busy_m     = 0;
                chk_result = 1;
                exp_result = ref_val;
            end
        end
    end

    // Requesters drop Req once their Ack has been seen.
    task automatic step();
        @(posedge Clk);
        #4;
        Req = Req & ~acked;
    endtask

    task automatic raise(input int i, input logic [1:0] op, input logic [11:0] d,
                         input logic [3:0] b);
        Req[i]          = 1'b1;
        Op[2*i +: 2]    = op;
        Data[W*i +: W]  = d;
        Burst[BW*i +: BW] = b;
    endtask

    task automatic wait_all();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((Req != '0 || busy_m || chk_result) && n < 400);
        check("timeout", 32'(n < 400), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0;
        Req   = '0;
        Op    = '0;
        Data  = '0;
        Burst = '0;
        repeat (3) @(posedge Clk);
        #4;
        check("rst_grant", 32'(Grant), 32'd0);
        check("rst_ack", 32'(Ack), 32'd0);
        check("rst_req", 32'(CntRequest), 32'd0);
        check("rst_dec", 32'(CntDec), 32'd0);
        check("rst_set", 32'(CntSet), 32'd0);
        check("rst_result", 32'(Result), 32'd0);
        check("rst_zero", 32'(ResultZero), 32'd1);
        check("rst_cntin", 32'(CntIn), 32'd0);
        Rst_n = 1'b1;
        step();

        raise(0, 2'b10, 12'h123, 4'd0);
        wait_all();
        check("set123", 32'(Result), 32'h123);

        raise(1, 2'b10, 12'h999, 4'd0);
        wait_all();
        raise(2, 2'b00, 12'h000, 4'd0);
        wait_all();
        check("wrap_result", 32'(Result), 32'h000);
        check("wrap_zero", 32'(ResultZero), 32'd1);

        // Pointer now 0; all three INC from 000, then requester 0 again.
        for (int i = 0; i < N; i++) raise(i, 2'b00, 12'h000, 4'd0);
        wait_all();
        raise(0, 2'b00, 12'h000, 4'd0);
        wait_all();
        check("rr_seq_result", 32'(Result), 32'h004);

        force_nr = 1'b1;
        raise(1, 2'b11, 12'h000, 4'd0);
        repeat (6) step();
        check("read_nogrant", 32'(Grant), 32'd0);
        force_nr = 1'b0;
        wait_all();
        check("read_result", 32'(Result), 32'h004);

        // Abort an op in its WAIT guard cycle.
        raise(0, 2'b00, 12'h000, 4'd0);
        wait_all();
        raise(1, 2'b00, 12'h000, 4'd0);
        begin
            int n;
            n = 0;
            while (Grant == '0 && n < 50) begin
                step();
                n++;
            end
        end
        step();
        Rst_n = 1'b0;
        Req   = '0;
        #1;
        check("abort_grant", 32'(Grant), 32'd0);
        check("abort_ack", 32'(Ack), 32'd0);
        check("abort_req", 32'(CntRequest), 32'd0);
        check("abort_dec", 32'(CntDec), 32'd0);
        check("abort_result", 32'(Result), 32'd0);
        check("abort_zero", 32'(ResultZero), 32'd1);
        repeat (2) step();
        Rst_n = 1'b1;
        repeat (4) step();
        for (int i = 0; i < N; i++) raise(i, 2'b11, 12'h000, 4'd0);
        wait_all();

`ifdef DCNT_ARB_BURST_EN
        raise(0, 2'b10, 12'h010, 4'd0);
        wait_all();
        raise(2, 2'b01, 12'h000, 4'd5);
        wait_all();
        check("burst_result", 32'(Result), 32'h005);
`endif

        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!Req[i] && $urandom_range(0, 3) == 0)
                    raise(i, 2'($urandom_range(0, 3)), int2bcd($urandom_range(0, 999)),
                          4'($urandom_range(0, 3)));
            end
        end
        wait_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
